// File: rtl/ddr_axi_burst_master.sv
// Single-outstanding AXI burst master: one 4-beat, 32-bit write or read per command.
// Define DDR_AXI_MASTER_TIMEOUT_EN to add an 8-bit watchdog that aborts a stalled burst.
module ddr_axi_burst_master (
    input  logic         ACLK,
    input  logic         ARESET,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_write,
    input  logic [31:0]  cmd_addr,
    input  logic [127:0] cmd_wdata,
    output logic         rsp_valid,
    output logic [127:0] rsp_rdata,
    output logic         rsp_err,
    output logic [31:0]  M0_AWADDR,
    output logic [3:0]   M0_AWLEN,
    output logic         M0_AWVALID,
    input  logic         M0_AWREADY,
    output logic [31:0]  M0_WDATA,
    output logic [3:0]   M0_WSTRB,
    output logic         M0_WLAST,
    output logic         M0_WVALID,
    input  logic         M0_WREADY,
    input  logic [1:0]   M0_BRESP,
    input  logic         M0_BVALID,
    output logic         M0_BREADY,
    output logic [31:0]  M0_ARADDR,
    output logic [3:0]   M0_ARLEN,
    output logic         M0_ARVALID,
    input  logic         M0_ARREADY,
    input  logic [31:0]  M0_RDATA,
    input  logic [1:0]   M0_RRESP,
    input  logic         M0_RLAST,
    input  logic         M0_RVALID,
    output logic         M0_RREADY
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] AW   = 3'd1;
    localparam logic [2:0] W    = 3'd2;
    localparam logic [2:0] B    = 3'd3;
    localparam logic [2:0] AR   = 3'd4;
    localparam logic [2:0] R    = 3'd5;

    logic [2:0]   state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [127:0] data_q, data_d;
    logic [127:0] rdata_q, rdata_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         err_q, err_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_err_q, rsp_err_d;
    logic         aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Hold off new commands during the response pulse so a new burst starts a cycle later.
    assign cmd_ready  = (state_q == IDLE) && !rsp_valid_q;

    assign M0_AWVALID = (state_q == AW);
    assign M0_AWADDR  = addr_q;
    assign M0_AWLEN   = M0_AWVALID ? 4'd3 : 4'd0;
    assign M0_WVALID  = (state_q == W);
    assign M0_WDATA   = data_q[{cnt_q, 5'd0} +: 32];
    assign M0_WSTRB   = M0_WVALID ? 4'hF : 4'h0;
    assign M0_WLAST   = M0_WVALID && (cnt_q == 2'd3);
    assign M0_BREADY  = (state_q == B);
    assign M0_ARVALID = (state_q == AR);
    assign M0_ARADDR  = addr_q;
    assign M0_ARLEN   = M0_ARVALID ? 4'd3 : 4'd0;
    assign M0_RREADY  = (state_q == R);

    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rdata_q;

    assign aw_hs = M0_AWVALID && M0_AWREADY;
    assign w_hs  = M0_WVALID && M0_WREADY;
    assign b_hs  = M0_BREADY && M0_BVALID;
    assign ar_hs = M0_ARVALID && M0_ARREADY;
    assign r_hs  = M0_RREADY && M0_RVALID;

`ifdef DDR_AXI_MASTER_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
    logic       any_hs;
    assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = cmd_write ? AW : AR;
                    addr_d  = cmd_addr;
                    // Reads start from a zeroed buffer so unreceived beats read back as 0.
                    data_d  = cmd_write ? cmd_wdata : '0;
                    cnt_d   = 2'd0;
                    err_d   = 1'b0;
                end
            end
            AW: if (aw_hs) state_d = W;
            W: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = B;
                end
            end
            B: begin
                if (b_hs) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (M0_BRESP != 2'b00);
                end
            end
            AR: if (ar_hs) state_d = R;
            R: begin
                if (r_hs) begin
                    data_d[{cnt_q, 5'd0} +: 32] = M0_RDATA;
                    err_d = err_q || (M0_RRESP != 2'b00);
                    cnt_d = cnt_q + 2'd1;
                    if ((cnt_q == 2'd3) || M0_RLAST) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = err_d || (cnt_q != 2'd3) || !M0_RLAST;
                        rdata_d     = data_d;
                        cnt_d       = 2'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef DDR_AXI_MASTER_TIMEOUT_EN
        wd_d = (state_q == IDLE || any_hs) ? 8'd0 : wd_q + 8'd1;
        // 255th consecutive cycle without a handshake: abort and report an error.
        if (state_q != IDLE && !any_hs && wd_q == 8'd254) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            cnt_d       = 2'd0;
            wd_d        = 8'd0;
        end
`endif
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef DDR_AXI_MASTER_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DDR_AXI_MASTER_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

endmodule

// File: tb/tb_ddr_axi_burst_master.sv
// Directed bench for ddr_axi_burst_master: the bench plays the AXI slave and checks each
// transfer against hand-computed values.
module tb_ddr_axi_burst_master;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic         cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0]  cmd_addr = '0;
    logic [127:0] cmd_wdata = '0;
    logic         rsp_valid, rsp_err;
    logic [127:0] rsp_rdata;
    logic [31:0]  M0_AWADDR, M0_WDATA, M0_ARADDR;
    logic [3:0]   M0_AWLEN, M0_WSTRB, M0_ARLEN;
    logic         M0_AWVALID, M0_WLAST, M0_WVALID, M0_BREADY, M0_ARVALID, M0_RREADY;
    logic         M0_AWREADY = 1'b0, M0_WREADY = 1'b0, M0_BVALID = 1'b0;
    logic         M0_ARREADY = 1'b0, M0_RLAST = 1'b0, M0_RVALID = 1'b0;
    logic [1:0]   M0_BRESP = '0, M0_RRESP = '0;
    logic [31:0]  M0_RDATA = '0;

    int checks = 0;
    int errors = 0;
    int w_hs_cnt = 0;
    int rsp_cnt = 0;

    always #5 ACLK = ~ACLK;

    ddr_axi_burst_master dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M0_AWADDR(M0_AWADDR), .M0_AWLEN(M0_AWLEN), .M0_AWVALID(M0_AWVALID),
        .M0_AWREADY(M0_AWREADY),
        .M0_WDATA(M0_WDATA), .M0_WSTRB(M0_WSTRB), .M0_WLAST(M0_WLAST),
        .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
        .M0_BRESP(M0_BRESP), .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
        .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARVALID(M0_ARVALID),
        .M0_ARREADY(M0_ARREADY),
        .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST),
        .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY)
    );

    always @(posedge ACLK) begin
        if (M0_WVALID && M0_WREADY) w_hs_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {M0_AWVALID, M0_WVALID, M0_WLAST, M0_BREADY, M0_ARVALID,
                              M0_RREADY, rsp_valid, rsp_err, M0_AWLEN, M0_ARLEN, M0_WSTRB}, '0);
        check({tag, "_addr"}, {M0_AWADDR, M0_ARADDR, M0_WDATA}, '0);
        check({tag, "_rdata"}, rsp_rdata, '0);
    endtask

    task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [127:0] d);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic run_write(input logic [31:0] a, input logic [127:0] wd, input int aw_stall,
                             input bit w_toggle, input logic [1:0] bresp, input bit skip_b);
        int beat = 0;
        int t = 0;
        bit wr;
        issue_cmd(1'b1, a, wd);
        check("awvalid", M0_AWVALID, 1'b1);
        check("awlen", M0_AWLEN, 4'd3);
        check("arvalid_in_write", M0_ARVALID, 1'b0);
        for (int i = 0; i < aw_stall; i++) begin
            check("awaddr_stall", {M0_AWVALID, M0_AWADDR}, {1'b1, a});
            @(negedge ACLK);
        end
        check("awaddr", M0_AWADDR, a);
        M0_AWREADY = 1'b1;
        @(negedge ACLK);
        M0_AWREADY = 1'b0;
        check("wstrb", M0_WSTRB, 4'hF);
        while (beat < 4 && t < 40) begin
            wr = w_toggle ? t[0] : 1'b1;
            check("wvalid", M0_WVALID, 1'b1);
            check("wdata", M0_WDATA, wd[beat*32 +: 32]);
            check("wlast", M0_WLAST, beat == 3);
            M0_WREADY = wr;
            @(negedge ACLK);
            if (wr) beat++;
            t++;
        end
        M0_WREADY = 1'b0;
        check("w_beats", beat, 4);
        if (!skip_b) begin
            check("bready", M0_BREADY, 1'b1);
            check("wvalid_in_b", {M0_WVALID, M0_WLAST}, 2'b00);
            M0_BVALID = 1'b1;
            M0_BRESP  = bresp;
            @(negedge ACLK);
            M0_BVALID = 1'b0;
            M0_BRESP  = 2'b00;
            check("rsp_valid_w", rsp_valid, 1'b1);
            check("rsp_err_w", rsp_err, bresp != 2'b00);
            @(negedge ACLK);
            check("rsp_pulse_w", rsp_valid, 1'b0);
            check("idle_after_w", {cmd_ready, M0_BREADY}, 2'b10);
        end
    endtask

    task automatic run_read(input logic [31:0] a, input logic [127:0] beats, input int rlast_at,
                            input bit gaps, input logic [127:0] exp_rdata, input bit exp_err);
        issue_cmd(1'b0, a, '0);
        check("arvalid", M0_ARVALID, 1'b1);
        check("arlen", M0_ARLEN, 4'd3);
        check("araddr", M0_ARADDR, a);
        check("awvalid_in_read", {M0_AWVALID, M0_WVALID}, 2'b00);
        M0_ARREADY = 1'b1;
        @(negedge ACLK);
        M0_ARREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rready", M0_RREADY, 1'b1);
            if (gaps) repeat (i) @(negedge ACLK);
            M0_RVALID = 1'b1;
            M0_RDATA  = beats[i*32 +: 32];
            M0_RLAST  = (i == rlast_at);
            @(negedge ACLK);
            M0_RVALID = 1'b0;
            M0_RLAST  = 1'b0;
            if (i == rlast_at) break;
        end
        check("rsp_valid_r", rsp_valid, 1'b1);
        check("rsp_err_r", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        @(negedge ACLK);
        check("rsp_pulse_r", rsp_valid, 1'b0);
        check("idle_after_r", {cmd_ready, M0_RREADY}, 2'b10);
        check("rsp_rdata_held", rsp_rdata, exp_rdata);
    endtask

    initial begin
        int hs0;
        int rc0;
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset");
        ARESET = 1'b0;
        @(negedge ACLK);
        check("cmd_ready_after_reset", cmd_ready, 1'b1);

        run_write(32'h0000_0000, 128'h87654321_12345678_C0DECAFE_DEADBEEF, 0, 1'b0, 2'b00, 1'b0);
        run_read(32'h0000_1000, 128'h41594148_DEC0DED1_FEEDDEED_FADEDEAF, 3, 1'b1,
                 128'h41594148_DEC0DED1_FEEDDEED_FADEDEAF, 1'b0);

        hs0 = w_hs_cnt;
        run_write(32'h2000_0040, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 5, 1'b1, 2'b00, 1'b0);
        check("w_handshakes", w_hs_cnt - hs0, 4);

        run_write(32'h0000_2000, 128'h44444444_33333333_22222222_11111111, 0, 1'b0, 2'b10, 1'b0);
        run_read(32'h0000_3000, 128'h11111111_22222222_33333333_44444444, 2, 1'b0,
                 128'h00000000_22222222_33333333_44444444, 1'b1);

        // Reset in the middle of write beat 2.
        rc0 = rsp_cnt;
        issue_cmd(1'b1, 32'h0000_4000, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
        M0_AWREADY = 1'b1;
        @(negedge ACLK);
        M0_AWREADY = 1'b0;
        M0_WREADY  = 1'b1;
        repeat (2) @(negedge ACLK);
        check("wdata_beat2", M0_WDATA, 32'h0C0C0C0C);
        M0_WREADY = 1'b0;
        ARESET    = 1'b1;
        @(negedge ACLK);
        check_reset_outputs("mid_reset");
        ARESET = 1'b0;
        @(negedge ACLK);
        check("cmd_ready_post_reset", cmd_ready, 1'b1);
        check("no_rsp_on_reset", rsp_cnt - rc0, 0);
        run_write(32'h0000_5000, 128'h99999999_88888888_77777777_66666666, 0, 1'b0, 2'b00, 1'b0);

`ifdef DDR_AXI_MASTER_TIMEOUT_EN
        begin
            int nb = 0;
            run_write(32'h0000_6000, 128'h1, 0, 1'b0, 2'b00, 1'b1);
            while (M0_BREADY && nb < 400) begin
                nb++;
                @(negedge ACLK);
            end
            check("timeout_cycles", nb, 255);
            check("timeout_rsp", {rsp_valid, rsp_err, M0_BREADY}, 3'b110);
            @(negedge ACLK);
            check("timeout_idle", {rsp_valid, cmd_ready}, 2'b01);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/ddr_axi_burst_master.md
DDR_AXI_BURST_MASTER -- requirements
Module: ddr_axi_burst_master

Interface
REQ-001 SHALL have port ACLK  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port ARESET  input  1  synchronous, active-high reset.
REQ-003 SHALL have port cmd_valid  input  1  command request.
REQ-004 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-005 SHALL have port cmd_write  input  1  1 = 4-beat write, 0 = 4-beat read.
REQ-006 SHALL have port cmd_addr  input  32  burst start address, passed unmodified to AWADDR/ARADDR.
REQ-007 SHALL have port cmd_wdata  input  128  write payload; beat i = bits [32i+31:32i].
REQ-008 SHALL have port rsp_valid  output  1  one-cycle completion pulse, no backpressure.
REQ-009 SHALL have port rsp_rdata  output  128  read payload, same beat packing as cmd_wdata; held until next read completes.
REQ-010 SHALL have port rsp_err  output  1  error flag, valid with rsp_valid.
REQ-011 SHALL have ports M0_AWADDR out 32, M0_AWLEN out 4, M0_AWVALID out 1, M0_AWREADY in 1.
REQ-012 SHALL have ports M0_WDATA out 32, M0_WSTRB out 4, M0_WLAST out 1, M0_WVALID out 1, M0_WREADY in 1.
REQ-013 SHALL have ports M0_BRESP in 2, M0_BVALID in 1, M0_BREADY out 1.
REQ-014 SHALL have ports M0_ARADDR out 32, M0_ARLEN out 4, M0_ARVALID out 1, M0_ARREADY in 1.
REQ-015 SHALL have ports M0_RDATA in 32, M0_RRESP in 2, M0_RLAST in 1, M0_RVALID in 1, M0_RREADY out 1.

Function
REQ-016 SHALL implement FSM states IDLE, AW, W, B, AR, R; cmd_ready = 1 only in IDLE.
REQ-017 SHALL on command accept latch addr/data and enter AW (cmd_write=1) or AR (cmd_write=0); AWVALID/ARVALID assert the following cycle.
REQ-018 SHALL drive AWLEN = ARLEN = 4'd3 and WSTRB = 4'hF for every burst.
REQ-019 SHALL hold AWVALID and AWADDR stable until AWVALID & AWREADY, then enter W next cycle.
REQ-020 SHALL in W drive WVALID continuously, advance beat counter 0..3 only on WVALID & WREADY, WDATA = latched beat[count], WLAST = 1 exactly when count = 3.
REQ-021 SHALL after beat 3 handshake enter B, deassert WVALID/WLAST, assert BREADY.
REQ-022 SHALL on BVALID & BREADY pulse rsp_valid, set rsp_err = (BRESP != 2'b00), return to IDLE.
REQ-023 SHALL hold ARVALID and ARADDR stable until ARVALID & ARREADY, then enter R with RREADY = 1.
REQ-024 SHALL in R store RDATA into beat[count] on each RVALID & RREADY, count 0..3.
REQ-025 SHALL complete read on 4th beat: pulse rsp_valid, rsp_err = any RRESP != 0 OR RLAST mismatch (RLAST high on beats 0-2, or low on beat 3).
REQ-026 SHALL on early RLAST (beat 0-2) complete immediately with rsp_err = 1; unreceived beats of rsp_rdata read as 0.
REQ-027 SHALL ignore cmd_valid while not in IDLE; back-to-back commands accepted earliest one cycle after rsp_valid.
REQ-028 SHALL never assert AWVALID/WVALID and ARVALID simultaneously (one burst outstanding).

Reset
REQ-029 SHALL on ARESET = 1 at a clock edge enter IDLE, clear beat counter and error state, drive all VALID/READY/LAST outputs, rsp_valid, rsp_err to 0, address/data outputs and rsp_rdata to 0.
REQ-030 SHALL on reset mid-burst abandon the burst with no rsp_valid; cmd_ready = 1 the first cycle after ARESET deasserts.

Configuration
REQ-031 SHALL with DDR_AXI_MASTER_TIMEOUT_EN defined run an 8-bit watchdog in AW, W, B, AR, R, cleared on every handshake; at 255 idle cycles it deasserts all AXI VALID/READY, pulses rsp_valid with rsp_err = 1, returns to IDLE.
REQ-032 SHALL without DDR_AXI_MASTER_TIMEOUT_EN wait indefinitely in any state; no watchdog logic is present.

Verification
REQ-033 SHALL cover: write 0x0000_0000, wdata {87654321,12345678,C0DECAFE,DEADBEEF}, responder always ready, BRESP=00 -> AWLEN=3, WDATA DEADBEEF..87654321, WLAST on beat 4 only, rsp_err=0.
REQ-034 SHALL cover: read 0x0000_1000, responder returns FADEDEAF,FEEDDEED,DEC0DED1,41594148 with RVALID gaps -> rsp_rdata = {41594148,DEC0DED1,FEEDDEED,FADEDEAF}, rsp_err=0.
REQ-035 SHALL cover: AWREADY held low 5 cycles, WREADY toggling -> AWADDR/WDATA stable while stalled, exactly 4 W handshakes.
REQ-036 SHALL cover: BRESP=2'b10 on write; RLAST on read beat 2 -> rsp_err=1 each, FSM back in IDLE.
REQ-037 SHALL cover: ARESET asserted during W beat 2 -> no rsp_valid, all outputs 0, next write completes normally.
REQ-038 SHALL cover (TIMEOUT_EN defined): BVALID never asserted -> rsp_valid with rsp_err=1 exactly 255 cycles after W completion.
